// File: rtl/ka_193bit.sv
// Pipelined carry-less (GF(2)[x]) multiplier, 193x193 -> 385 bits, built from a
// recursive Karatsuba network between two register stages (latency 2, one op per cycle).
module ka_193bit #(
    parameter int W      = 193,
    parameter int LEAF_W = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    output logic             out_valid,
    output logic [2*W-2:0]   y
);

    logic [W-1:0]   r_a;
    logic [W-1:0]   r_b;
    logic           r_vld;
    logic [2*W-2:0] r_y;
    logic           r_out_vld;
    logic [2*W-2:0] w_prod;

    // Stage 1: operands and valid load every cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a   <= '0;
            r_b   <= '0;
            r_vld <= 1'b0;
        end else begin
            r_a   <= a;
            r_b   <= b;
            r_vld <= in_valid;
        end
    end

    ka_193bit_mul #(
        .N      (W),
        .LEAF_W (LEAF_W)
    ) u_mul (
        .i_a (r_a),
        .i_b (r_b),
        .o_y (w_prod)
    );

    // Stage 2: the product only updates on a valid slot so y holds across gaps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_y       <= '0;
            r_out_vld <= 1'b0;
        end else begin
            r_out_vld <= r_vld;
            if (r_vld) begin
                r_y <= w_prod;
            end else begin
                r_y <= r_y;
            end
        end
    end

    assign y         = r_y;
    assign out_valid = r_out_vld;

endmodule

// Combinational Karatsuba carry-less multiplier, recursing until N <= LEAF_W.
module ka_193bit_mul #(
    parameter int N      = 193,
    parameter int LEAF_W = 12
) (
    input  logic [N-1:0]   i_a,
    input  logic [N-1:0]   i_b,
    output logic [2*N-2:0] o_y
);

    if (N <= LEAF_W) begin : g_leaf
        // Schoolbook AND/XOR product.
        always_comb begin
            o_y = '0;
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    o_y[i+j] = o_y[i+j] ^ (i_a[i] & i_b[j]);
                end
            end
        end
    end else begin : g_split
        localparam int H  = (N + 1) / 2;
        localparam int NH = N - H;

        logic [H-1:0]    w_sa;
        logic [H-1:0]    w_sb;
        logic [2*H-2:0]  w_p0;
        logic [2*H-2:0]  w_p1;
        logic [2*NH-2:0] w_p2;
        logic [2*H-2:0]  w_mid;

        // lo ^ hi with hi zero-extended to H bits.
        always_comb begin
            w_sa          = i_a[H-1:0];
            w_sb          = i_b[H-1:0];
            w_sa[NH-1:0]  = w_sa[NH-1:0] ^ i_a[N-1:H];
            w_sb[NH-1:0]  = w_sb[NH-1:0] ^ i_b[N-1:H];
        end

        ka_193bit_mul #(.N(H),  .LEAF_W(LEAF_W)) u_p0 (.i_a(i_a[H-1:0]), .i_b(i_b[H-1:0]), .o_y(w_p0));
        ka_193bit_mul #(.N(H),  .LEAF_W(LEAF_W)) u_p1 (.i_a(w_sa),       .i_b(w_sb),       .o_y(w_p1));
        // The high half is multiplied at its true width so P2 lands exactly on the top output bit.
        ka_193bit_mul #(.N(NH), .LEAF_W(LEAF_W)) u_p2 (.i_a(i_a[N-1:H]), .i_b(i_b[N-1:H]), .o_y(w_p2));

        // Middle term P0 ^ P1 ^ P2.
        always_comb begin
            w_mid              = w_p0 ^ w_p1;
            w_mid[2*NH-2:0]    = w_mid[2*NH-2:0] ^ w_p2;
        end

        // Recombine: P0 ^ (mid << H) ^ (P2 << 2H).
        always_comb begin
            o_y                = '0;
            o_y[2*H-2:0]       = w_p0;
            o_y[3*H-2:H]       = o_y[3*H-2:H] ^ w_mid;
            o_y[2*N-2:2*H]     = o_y[2*N-2:2*H] ^ w_p2;
        end
    end

endmodule

// File: tb/tb_ka_193bit.sv
// Scoreboard bench for ka_193bit: expected products are queued when driven and
// compared (value and 2-cycle latency) when out_valid appears.
module tb_ka_193bit;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic [192:0] a;
    logic [192:0] b;
    logic         out_valid;
    logic [384:0] y;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    logic [384:0] exp_q[$];
    int           cyc_q[$];
    logic [384:0] last_y = '0;

    ka_193bit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .y         (y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle stamp used for latency checking.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [384:0] got, input logic [384:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Bit-serial carry-less reference product.
    function automatic logic [384:0] clmul(input logic [192:0] x, input logic [192:0] z);
        logic [384:0] acc;
        logic [384:0] sh;
        acc = '0;
        sh  = {192'd0, x};
        for (int i = 0; i < 193; i++) begin
            if (z[i]) acc = acc ^ sh;
            sh = sh << 1;
        end
        return acc;
    endfunction

    function automatic logic [192:0] rand193();
        logic [223:0] t;
        t = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        return t[192:0];
    endfunction

    task automatic monitor();
        logic [384:0] e;
        int           c;
        if (out_valid) begin
            if (exp_q.size() == 0) begin
                check_val("unexpected_valid", 385'd1, 385'd0);
            end else begin
                e = exp_q.pop_front();
                c = cyc_q.pop_front();
                check_val("product", y, e);
                check_val("latency", 385'(cyc - c), 385'd2);
                last_y = y;
            end
        end else begin
            check_val("hold_y", y, last_y);
        end
    endtask

    task automatic step(input bit v, input logic [192:0] ta, input logic [192:0] tb_, input logic [384:0] ex);
        @(negedge clk);
        monitor();
        in_valid = v;
        a        = ta;
        b        = tb_;
        if (v) begin
            exp_q.push_back(ex);
            cyc_q.push_back(cyc);
        end
    endtask

    task automatic step_m(input bit v, input logic [192:0] ta, input logic [192:0] tb_);
        step(v, ta, tb_, clmul(ta, tb_));
    endtask

    initial begin
        logic [192:0] ones;
        logic [192:0] top;
        logic [192:0] pa;
        logic [192:0] pb;
        logic [192:0] mask;
        logic [384:0] y_top;
        int           widths[6];

        ones     = '1;
        top      = '0;
        top[192] = 1'b1;
        y_top    = '0;
        y_top[384] = 1'b1;
        pa       = {113'd0, 80'h93B93B93B93B93B93B93};
        pb       = {113'd0, 80'hA2D168B45A2D168B45A2};
        widths   = '{7, 13, 25, 49, 97, 193};

        rst_n    = 1'b0;
        in_valid = 1'b0;
        a        = '0;
        b        = '0;
        #1;
        check_val("reset_valid", {384'd0, out_valid}, 385'd0);
        check_val("reset_y", y, 385'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed small values and extremes with constant expectations.
        step(1'b1, 193'd3, 193'd3, 385'd5);
        step(1'b0, 193'd0, 193'd0, 385'd0);
        step(1'b1, 193'd7, 193'd7, 385'h15);
        step(1'b1, 193'd1, 193'd2, 385'd2);
        step(1'b1, top, top, y_top);
        step(1'b1, ones, 193'd1, {192'd0, ones});
        step(1'b1, 193'd0, ones, 385'd0);
        step_m(1'b1, ones, ones);
        step_m(1'b1, pa, pb);
        step_m(1'b1, pb, pa);
        step(1'b0, 193'd0, 193'd0, 385'd0);
        step(1'b0, 193'd0, 193'd0, 385'd0);
        step(1'b0, 193'd0, 193'd0, 385'd0);

        // Mid-stream reset: in-flight results must be discarded.
        step_m(1'b1, rand193(), rand193());
        step_m(1'b1, rand193(), rand193());
        #3;
        rst_n = 1'b0;
        #1;
        check_val("midreset_valid", {384'd0, out_valid}, 385'd0);
        check_val("midreset_y", y, 385'd0);
        exp_q.delete();
        cyc_q.delete();
        last_y   = '0;
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) step(1'b0, 193'd0, 193'd0, 385'd0);

        // Leaf-boundary widths.
        foreach (widths[k]) begin
            mask = '1;
            mask = mask >> (193 - widths[k]);
            for (int i = 0; i < 6; i++) begin
                step_m(1'b1, rand193() & mask, rand193() & mask);
            end
        end

        // Random stream with gaps.
        for (int i = 0; i < 1000; i++) begin
            step_m($urandom_range(0, 3) != 0, rand193(), rand193());
        end

        for (int i = 0; i < 5; i++) step(1'b0, 193'd0, 193'd0, 385'd0);
        check_val("drain", 385'(exp_q.size()), 385'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
